// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl
// Decodes 10-bit SPI frames (2-bit command + 8-bit payload) into accesses on
// a register-file port and returns read bytes to the SPI slave.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_rx_data/valid     frame from the SPI deserialiser, one-cycle strobe
//   o_address, o_data   register-file address and write data (held between accesses)
//   o_wr_en             one-cycle register-file write enable
//   i_rd_data           register-file read data (registered read inside reg_file)
//   o_tx_data/valid     read byte for MISO, valid strobe is one cycle wide
//   o_busy              high while a data access is in flight
//   o_drop              one-cycle pulse after a frame arrives while busy
//
// Commands: 00 set write address, 01 write data, 10 set read address,
//           11 read data (payload ignored).
module reg_file_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [DATA_WIDTH+1:0]   i_rx_data,
    input  logic                    i_rx_valid,
    output logic [ADDRESS_SIZE-1:0] o_address,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_wr_en,
    input  logic [DATA_WIDTH-1:0]   i_rd_data,
    output logic [DATA_WIDTH-1:0]   o_tx_data,
    output logic                    o_tx_valid,
    output logic                    o_busy,
    output logic                    o_drop
);

    localparam logic [1:0] CMD_SET_WR = 2'b00;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_SET_RD = 2'b10;
    localparam logic [1:0] CMD_READ   = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        READ_REQ = 2'd2,
        READ_CAP = 2'd3
    } state_t;

    state_t                  state_q,    state_d;
    logic [ADDRESS_SIZE-1:0] wr_addr_q,  wr_addr_d;
    logic [ADDRESS_SIZE-1:0] rd_addr_q,  rd_addr_d;
    logic [ADDRESS_SIZE-1:0] address_q,  address_d;
    logic [DATA_WIDTH-1:0]   data_q,     data_d;
    logic                    wr_en_q,    wr_en_d;
    logic [DATA_WIDTH-1:0]   tx_data_q,  tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    drop_q,     drop_d;

    logic [1:0]              cmd;
    logic [DATA_WIDTH-1:0]   payload;

    assign cmd     = i_rx_data[DATA_WIDTH+1:DATA_WIDTH];
    assign payload = i_rx_data[DATA_WIDTH-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            address_q  <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            address_q  <= address_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        // Everything holds by default; the strobes default low so each is a
        // single-cycle pulse.
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        address_d  = address_q;
        data_d     = data_q;
        wr_en_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        drop_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    case (cmd)
                        CMD_SET_WR: wr_addr_d = ADDRESS_SIZE'(payload);
                        CMD_SET_RD: rd_addr_d = ADDRESS_SIZE'(payload);
                        CMD_WRITE: begin
                            address_d = wr_addr_q;
                            data_d    = payload;
                            wr_en_d   = 1'b1;
                            state_d   = WRITE;
                        end
                        CMD_READ: begin
                            address_d = rd_addr_q;
                            state_d   = READ_REQ;
                        end
                        default: ;
                    endcase
                end
            end
            // wr_en falls back to 0 by default, so the register file commits
            // on the edge that leaves this state.
            WRITE:    state_d = IDLE;
            // The register file samples o_address on the edge leaving this
            // state; its output is valid during READ_CAP.
            READ_REQ: state_d = READ_CAP;
            READ_CAP: begin
                tx_data_d  = i_rd_data;
                tx_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default:  state_d = IDLE;
        endcase

        // Any frame arriving outside IDLE is discarded without side effects.
        if (i_rx_valid && (state_q != IDLE)) begin
            drop_d = 1'b1;
        end
    end

    assign o_address  = address_q;
    assign o_data     = data_q;
    assign o_wr_en    = wr_en_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_drop     = drop_q;
    assign o_busy     = (state_q != IDLE);

endmodule

// File: doc/reg_file_ctrl.md
# reg_file_ctrl

Command controller that sits between the SPI slave's deserialiser and the `reg_file` storage block, acting as the sole initiator on the register-file port. It decodes 10-bit SPI frames (2-bit command plus 8-bit payload) into register-file address, write and read cycles. It returns read data as a single-cycle-valid byte for the SPI slave to shift out on MISO.

## Interface
- `DATA_WIDTH`, 8, payload and register width
- `ADDRESS_SIZE`, 8, register-file address width; must equal `DATA_WIDTH`
- `i_clk`  in  1  system clock, rising-edge
- `i_rst`  in  1  asynchronous, active-high reset
- `i_rx_data`  in  DATA_WIDTH+2  frame from SPI slave: [DATA_WIDTH+1:DATA_WIDTH] = cmd, [DATA_WIDTH-1:0] = payload
- `i_rx_valid`  in  1  frame strobe, one cycle per frame
- `o_address`  out  ADDRESS_SIZE  to reg_file `i_address`
- `o_data`  out  DATA_WIDTH  to reg_file `i_data`
- `o_wr_en`  out  1  to reg_file `i_wr_en`
- `i_rd_data`  in  DATA_WIDTH  from reg_file `o_data`
- `o_tx_data`  out  DATA_WIDTH  read byte to SPI slave
- `o_tx_valid`  out  1  one-cycle strobe qualifying `o_tx_data`
- `o_busy`  out  1  high while an access is in flight
- `o_drop`  out  1  one-cycle pulse when a frame is discarded

## Operation
- Command encoding:
  - 00 = set write address
  - 01 = write data
  - 10 = set read address
  - 11 = read data (payload ignored)
- Internal registers: `wr_addr`, `rd_addr` (separate, both reset to 0).
- FSM states: IDLE, WRITE, READ_REQ, READ_CAP. `o_busy` = (state != IDLE), combinational.
- IDLE transitions, on `i_rx_valid`:
  - cmd 00: `wr_addr` <= payload; stay IDLE.
  - cmd 10: `rd_addr` <= payload; stay IDLE.
  - cmd 01: `o_address` <= `wr_addr`, `o_data` <= payload, `o_wr_en` <= 1; go to WRITE.
  - cmd 11: `o_address` <= `rd_addr`, `o_wr_en` <= 0; go to READ_REQ.
- WRITE: `o_wr_en` <= 0; go to IDLE.
- READ_REQ: go to READ_CAP. The register file registers its read on this edge.
- READ_CAP: `o_tx_data` <= `i_rd_data`, `o_tx_valid` <= 1; go to IDLE.
- `o_tx_valid` is cleared on the following edge. `o_tx_data` holds its value until the next read.
- `o_address` and `o_data` change only when an access is issued; otherwise they hold.
- Boundary conditions:
  - Frame with `i_rx_valid` while busy: discarded with no state change, and `o_drop` pulses on the next cycle.
  - Read with no prior cmd 10: uses `rd_addr` = 0, or the last latched value.
  - Write with no prior cmd 00: uses `wr_addr` = 0, or the last latched value.
  - Address registers persist across accesses. Repeated cmd 01 frames write consecutive bytes to the same address (no auto-increment).
  - Address wraps trivially: all 2^ADDRESS_SIZE values are legal.

## Timing
- Reset (async, immediate):
  - state = IDLE
  - `o_address`, `o_data`, `o_tx_data`, `wr_addr`, `rd_addr` = 0
  - `o_wr_en`, `o_tx_valid`, `o_drop` = 0
- Reset mid-access: `o_wr_en` drops immediately and no `o_tx_valid` is produced.
- Edge numbering: frame sampled at edge N.
- Write: `o_wr_en` is high for exactly the cycle N..N+1, and reg_file commits at edge N+1. `o_busy` is high for that same cycle.
- Read:
  - `o_address` is valid after edge N.
  - `o_tx_valid` is high for the cycle after edge N+2, so latency is 2 clocks.
  - `o_busy` is high for 2 cycles.
- Set-address commands take effect at edge N with zero busy cycles. A data command on edge N+1 uses the new address.
- Earliest next accepted frame: edge N+1 after cmd 00/10, N+2 after cmd 01, N+3 after cmd 11.

## Test plan
- Frames are shown as 10-bit hex, listed in order, one per frame.
- Basic write: frames 0x002, 0x115 -> one-cycle `o_wr_en` with `o_address`=0x02, `o_data`=0x15.
- Second write plus read-back:
  - Frames 0x0A6, 0x199 write 0x99 to address 0xA6.
  - Frames 0x202, 0x384 -> `o_tx_valid` pulse 2 clocks after the 0x384 frame, with `o_tx_data`=0x15. `o_wr_en` stays 0 throughout.
- Overwrite: frames 0x0A6, 0x1FF, then 0x2A6, 0x3EA -> `o_tx_data`=0xFF. Address 0x02 still reads 0x15.
- Busy drop: frame 0x3xx, then another frame on the next edge -> second frame ignored, `o_drop` pulses once, and exactly one `o_tx_valid` is produced.
- Reset mid-access: assert `i_rst` during WRITE and during READ_REQ -> `o_wr_en` falls without waiting for a clock, no `o_tx_valid`, all outputs 0.
- Address-register defaults after reset: frame 0x377 -> read of address 0x00. Frame 0x1AB -> write of 0xAB to address 0x00.
